// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq -- reset sequencer downstream of the clock/reset manager.
//
// Releases NUM_DOM reset domains one after another, STAGE_CYC clk cycles apart,
// after a hard reset (rst_n) or after a warm reset.  A warm reset is requested
// by software (sw_rst_req) or the watchdog (wdt_rst_req).  It is honoured only
// once every domain is released.  It holds all domains low for HOLD_CYC cycles
// and then reruns the staged release.  The cause of the most recent warm reset
// is kept in rst_cause for firmware.
//
// Ports
//   clk          in   1        system clock
//   rst_n        in   1        async active-low hard reset
//   sw_rst_req   in   1        software warm-reset request (sampled on posedge)
//   wdt_rst_req  in   1        watchdog warm-reset request (sampled on posedge)
//   cause_clr    in   1        clears rst_cause (sampled on posedge)
//   dom_rst_n    out  NUM_DOM  per-domain active-low resets, registered
//   seq_done     out  1        1 = all domains released
//   rst_cause    out  2        {wdt,sw} cause of last warm reset; 00 = hard reset
// -----------------------------------------------------------------------------
module rst_seq #(
    parameter int NUM_DOM   = 4,
    parameter int STAGE_CYC = 16,
    parameter int HOLD_CYC  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    input  logic               wdt_rst_req,
    input  logic               cause_clr,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done,
    output logic [1:0]         rst_cause
);

    localparam int MAX_CYC = (STAGE_CYC > HOLD_CYC) ? STAGE_CYC : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        ST_STAGE,   // counting towards the next domain release
        ST_RUN,     // all domains released
        ST_HOLD     // warm reset: all domains held low
    } state_t;

    state_t             state,     state_nx;
    logic [CNT_W-1:0]   cnt,       cnt_nx;
    logic [IDX_W-1:0]   idx,       idx_nx;
    logic [NUM_DOM-1:0] dom_nx;
    logic               done_nx;
    logic [1:0]         cause_nx;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        dom_nx   = dom_rst_n;
        done_nx  = seq_done;
        cause_nx = rst_cause;

        // A warm reset captured below overrides this clear.
        if (cause_clr)
            cause_nx = 2'b00;

        case (state)
            ST_STAGE: begin
                if (cnt == STAGE_LAST) begin
                    cnt_nx      = '0;
                    dom_nx[idx] = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nx = ST_RUN;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (sw_rst_req || wdt_rst_req) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    dom_nx   = '0;
                    done_nx  = 1'b0;
                    cause_nx = {wdt_rst_req, sw_rst_req};
                end
            end

            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_STAGE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                state_nx = ST_STAGE;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_STAGE;
            cnt       <= '0;
            idx       <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            rst_cause <= 2'b00;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            dom_rst_n <= dom_nx;
            seq_done  <= done_nx;
            rst_cause <= cause_nx;
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_seq -- directed self-checking bench for rst_seq.
// Two instances share clk/rst_n: the default configuration (4 domains,
// STAGE_CYC=16, HOLD_CYC=8) and a minimal one (1 domain, 1/1 cycles).
// Inputs are driven and outputs sampled on the falling edge of clk.
// "After edge n" means at the falling edge following rising edge n.
// -----------------------------------------------------------------------------
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst_req, wdt_rst_req, cause_clr;
    logic [3:0] dom_rst_n;
    logic       seq_done;
    logic [1:0] rst_cause;

    logic       sw1, wdt1, clr1;
    logic [0:0] dom1;
    logic       done1;
    logic [1:0] cause1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rst_seq #(.NUM_DOM(4), .STAGE_CYC(16), .HOLD_CYC(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .wdt_rst_req (wdt_rst_req),
        .cause_clr   (cause_clr),
        .dom_rst_n   (dom_rst_n),
        .seq_done    (seq_done),
        .rst_cause   (rst_cause)
    );

    rst_seq #(.NUM_DOM(1), .STAGE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw1),
        .wdt_rst_req (wdt1),
        .cause_clr   (clr1),
        .dom_rst_n   (dom1),
        .seq_done    (done1),
        .rst_cause   (cause1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [3:0] dom,
                             input logic done, input logic [1:0] cause);
        check({tag, ".dom"},   {4'h0, dom_rst_n}, {4'h0, dom});
        check({tag, ".done"},  {7'h0, seq_done},  {7'h0, done});
        check({tag, ".cause"}, {6'h0, rst_cause}, {6'h0, cause});
    endtask

    // Called right after rst_n is released on a falling edge.
    task automatic hard_seq(input string tag);
        tick(1);
        check({tag, ".min_e1.dom"},  {7'h0, dom1},  8'h01);
        check({tag, ".min_e1.done"}, {7'h0, done1}, 8'h01);
        tick(14); check_out({tag, ".e15"}, 4'b0000, 1'b0, 2'b00);
        tick(1);  check_out({tag, ".e16"}, 4'b0001, 1'b0, 2'b00);
        tick(15); check_out({tag, ".e31"}, 4'b0001, 1'b0, 2'b00);
        tick(1);  check_out({tag, ".e32"}, 4'b0011, 1'b0, 2'b00);
        tick(16); check_out({tag, ".e48"}, 4'b0111, 1'b0, 2'b00);
        tick(15); check_out({tag, ".e63"}, 4'b0111, 1'b0, 2'b00);
        tick(1);  check_out({tag, ".e64"}, 4'b1111, 1'b1, 2'b00);
    endtask

    // Called right after the warm-reset edge k; checks release timing.
    task automatic warm_seq(input string tag, input logic [1:0] cause);
        tick(23); check_out({tag, ".k23"}, 4'b0000, 1'b0, cause);
        tick(1);  check_out({tag, ".k24"}, 4'b0001, 1'b0, cause);
        tick(47); check_out({tag, ".k71"}, 4'b0111, 1'b0, cause);
        tick(1);  check_out({tag, ".k72"}, 4'b1111, 1'b1, cause);
    endtask

    initial begin
        rst_n = 1'b0;
        {sw_rst_req, wdt_rst_req, cause_clr} = '0;
        {sw1, wdt1, clr1} = '0;

        // Reset state.
        tick(3);
        check_out("rst", 4'b0000, 1'b0, 2'b00);

        // 1: hard release sequence.
        rst_n = 1'b1;
        hard_seq("t1");

        // 2: software warm reset.
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        check_out("t2.k", 4'b0000, 1'b0, 2'b01);
        warm_seq("t2", 2'b01);

        // 3: simultaneous requests, clear, and wdt winning over clear.
        sw_rst_req = 1'b1; wdt_rst_req = 1'b1; tick(1);
        sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
        check_out("t3.both", 4'b0000, 1'b0, 2'b11);
        tick(72);
        check_out("t3.run", 4'b1111, 1'b1, 2'b11);
        cause_clr = 1'b1; tick(1); cause_clr = 1'b0;
        check_out("t3.clr", 4'b1111, 1'b1, 2'b00);
        wdt_rst_req = 1'b1; cause_clr = 1'b1; tick(1);
        wdt_rst_req = 1'b0; cause_clr = 1'b0;
        check_out("t3.wdt_clr", 4'b0000, 1'b0, 2'b10);

        // 4: requests during HOLD (k+4) and STAGE (k+14) are ignored.
        tick(3);
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        check_out("t4.hold", 4'b0000, 1'b0, 2'b10);
        tick(9);
        wdt_rst_req = 1'b1; tick(1); wdt_rst_req = 1'b0;
        check_out("t4.stage", 4'b0000, 1'b0, 2'b10);
        tick(9);  check_out("t4.k23", 4'b0000, 1'b0, 2'b10);
        tick(1);  check_out("t4.k24", 4'b0001, 1'b0, 2'b10);
        tick(47); check_out("t4.k71", 4'b0111, 1'b0, 2'b10);
        tick(1);  check_out("t4.k72", 4'b1111, 1'b1, 2'b10);

        // 5: async reset mid-HOLD, wdt pulse at hard edge 20, reset mid-STAGE.
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        check_out("t5.warm", 4'b0000, 1'b0, 2'b01);
        tick(3);
        #1 rst_n = 1'b0;
        #1 check_out("t5.async_hold", 4'b0000, 1'b0, 2'b00);
        tick(2);
        rst_n = 1'b1;
        tick(19);
        wdt_rst_req = 1'b1; tick(1); wdt_rst_req = 1'b0;
        check_out("t5.e20", 4'b0001, 1'b0, 2'b00);
        tick(11); check_out("t5.e31", 4'b0001, 1'b0, 2'b00);
        tick(1);  check_out("t5.e32", 4'b0011, 1'b0, 2'b00);
        tick(8);
        #1 rst_n = 1'b0;
        #1 check_out("t5.async_stage", 4'b0000, 1'b0, 2'b00);
        tick(2);
        rst_n = 1'b1;
        hard_seq("t5.re");

        // 6: minimal configuration warm reset releases at k+2.
        sw1 = 1'b1; tick(1); sw1 = 1'b0;
        check("t6.k.dom",    {7'h0, dom1},   8'h00);
        check("t6.k.done",   {7'h0, done1},  8'h00);
        check("t6.k.cause",  {6'h0, cause1}, 8'h01);
        tick(1);
        check("t6.k1.dom",   {7'h0, dom1},   8'h00);
        tick(1);
        check("t6.k2.dom",   {7'h0, dom1},   8'h01);
        check("t6.k2.done",  {7'h0, done1},  8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
